// File: rtl/synchronous_down_counter_dflow_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | synchronous_down_counter_dflow_pkg                                   |
// | Shared constants for the data-flow down counter.                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package synchronous_down_counter_dflow_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage : synchronous_down_counter_dflow_pkg
`default_nettype wire

// File: rtl/synchronous_down_counter_dflow_dff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dff_sync_rst                                                         |
// | 1-bit D flip-flop with synchronous active-high clear.                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dff_sync_rst (
  output logic q,
  input  logic d,
  input  logic clk,
  input  logic rst
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule : dff_sync_rst
`default_nettype wire

// File: rtl/synchronous_down_counter_dflow.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | synchronous_down_counter_dflow                                       |
// | Free-running binary down counter: borrow-chain next state, one flop  |
// | per bit.                                                             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module synchronous_down_counter_dflow
  import synchronous_down_counter_dflow_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic             rst
);

  logic [WIDTH-1:0] borrow;
  logic [WIDTH-1:0] next_state;

  assign borrow[0] = 1'b1;

  // Clear is applied inside each flop, so next_state carries only the decrement.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign next_state[i] = out[i] ^ borrow[i];

    if (i < WIDTH - 1) begin : g_borrow
      assign borrow[i+1] = borrow[i] & ~out[i];
    end

    dff_sync_rst u_dff (
      .q   (out[i]),
      .d   (next_state[i]),
      .clk (clk),
      .rst (rst)
    );
  end

endmodule : synchronous_down_counter_dflow
`default_nettype wire

// File: tb/tb_synchronous_down_counter_dflow.sv
`default_nettype none
// Scoreboard bench: stimulus pushes model values per edge, a negedge monitor pops and compares
// against three counter widths (1, 4, 8) sharing one clock and reset.
module tb_synchronous_down_counter_dflow;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] out4;
  logic [0:0] out1;
  logic [7:0] out8;

  int checks = 0;
  int passed = 0;
  int n_since_reset = 0;

  typedef struct {
    int          edge_no;
    logic [7:0]  e1;
    logic [7:0]  e4;
    logic [7:0]  e8;
  } exp_t;

  exp_t sb[$];
  int   edge_count = 0;

  always #5 clk = ~clk;

  synchronous_down_counter_dflow dut (
    .out (out4),
    .clk (clk),
    .rst (rst)
  );

  synchronous_down_counter_dflow #(.WIDTH(1)) dut_w1 (
    .out (out1),
    .clk (clk),
    .rst (rst)
  );

  synchronous_down_counter_dflow #(.WIDTH(8)) dut_w8 (
    .out (out8),
    .clk (clk),
    .rst (rst)
  );

  // After n decrements from zero the count is (-n) mod 2^w.
  function automatic logic [7:0] model(input int n, input int w);
    int m;
    m = 1 << w;
    return 8'((m - (n % m)) % m);
  endfunction

  task automatic check(input string name, input int edge_no,
                       input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual === expected) begin
      passed++;
    end else begin
      $display("FAIL %s edge %0d: got 0x%0h, expected 0x%0h", name, edge_no, actual, expected);
    end
  endtask

  task automatic step(input logic r);
    exp_t e;
    rst = r;
    @(posedge clk);
    #1;
    edge_count++;
    if (r) n_since_reset = 0;
    else   n_since_reset++;
    e.edge_no = edge_count;
    e.e1 = model(n_since_reset, 1);
    e.e4 = model(n_since_reset, 4);
    e.e8 = model(n_since_reset, 8);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("w4", e.edge_no, {4'b0, out4}, e.e4);
      check("w1", e.edge_no, {7'b0, out1}, e.e1);
      check("w8", e.edge_no, out8, e.e8);
    end
  end

  initial begin
    // Reset out of X, then hold it.
    repeat (4) step(1'b1);
    // Full cycle plus wrap.
    repeat (17) step(1'b0);
    // Long run from reset, ending at 0xC for the 4-bit counter.
    step(1'b1);
    repeat (36) step(1'b0);
    // Reach 0x9, reset mid-count, resume.
    step(1'b1);
    repeat (7) step(1'b0);
    step(1'b1);
    step(1'b0);
    // Reset priority exactly at zero.
    step(1'b1);
    repeat (16) step(1'b0);
    step(1'b1);
    step(1'b0);
    // 8-bit full period back to zero.
    step(1'b1);
    repeat (257) step(1'b0);
    // Random reset pulses.
    for (int k = 0; k < 200; k++) begin
      step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    end

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      passed++;
    end else begin
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_synchronous_down_counter_dflow
`default_nettype wire
